// File: rtl/scm_fifo_ctrl.sv
// Streaming valid/ready FIFO controller in front of a two-port SCM macro.
// A 2-entry skid buffer on DOUT hides the one-cycle read latency.
module scm_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,

    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  RE,
    output logic [ADDR_WIDTH-1:0] RADDR,
    output logic                  SE,
    input  logic [DATA_WIDTH-1:0] DOUT,

    output logic [ADDR_WIDTH+1:0] count
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic       push;
    logic       pop;
    logic       re;
    logic [2:0] buf_occ;

    // Handshakes and memory strobes, all from registered state plus inputs.
    always_comb begin
        in_ready  = !RST && (mem_cnt_q < DEPTH_C);
        push      = in_valid && in_ready;
        out_valid = (buf_cnt_q != 2'd0);
        pop       = out_valid && out_ready;
        // Buffer slots that will be taken after this edge if no new read is issued.
        buf_occ   = 3'(buf_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        re        = !RST && (mem_cnt_q != '0) && (buf_occ < 3'd2);
    end

    assign WE       = push;
    assign WADDR    = wptr_q;
    assign DIN      = in_data;
    assign RE       = re;
    assign RADDR    = rptr_q;
    assign SE       = 1'b0;
    assign out_data = buf_q[head_q];
    assign count    = (ADDR_WIDTH + 2)'(mem_cnt_q)
                    + (ADDR_WIDTH + 2)'(rd_inflight_q)
                    + (ADDR_WIDTH + 2)'(buf_cnt_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        mem_cnt_d     = mem_cnt_q;
        rd_inflight_d = rd_inflight_q;
        buf_cnt_d     = buf_cnt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_d         = buf_q;

        if (RST) begin
            // A read already in flight is dropped: DOUT is not captured this edge.
            wptr_d        = '0;
            rptr_d        = '0;
            mem_cnt_d     = '0;
            rd_inflight_d = 1'b0;
            buf_cnt_d     = 2'd0;
            head_d        = 1'b0;
            tail_d        = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (re) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push && !re) begin
                mem_cnt_d = mem_cnt_q + 1'b1;
            end else if (!push && re) begin
                mem_cnt_d = mem_cnt_q - 1'b1;
            end
            rd_inflight_d = re;
            buf_cnt_d     = buf_occ[1:0];
            if (rd_inflight_q) begin
                buf_d[tail_q] = DOUT;
                tail_d        = !tail_q;
            end
            if (pop) begin
                head_d = !head_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        wptr_q        <= wptr_d;
        rptr_q        <= rptr_d;
        mem_cnt_q     <= mem_cnt_d;
        rd_inflight_q <= rd_inflight_d;
        buf_cnt_q     <= buf_cnt_d;
        head_q        <= head_d;
        tail_q        <= tail_d;
    end

    // NOTE: buffer storage is deliberately not reset; buf_cnt_q alone decides what is valid.
    always_ff @(posedge CLK) begin
        buf_q[0] <= buf_d[0];
        buf_q[1] <= buf_d[1];
    end

endmodule

// File: doc/scm_fifo_ctrl.md
# scm_fifo_ctrl

FIFO controller that turns the two-port standard-cell memory (scm65) into a valid/ready streaming FIFO. It sits directly upstream of the memory: it generates WE/WADDR/DIN from a producer handshake and RE/RADDR from consumer demand. It captures DOUT into a 2-entry output buffer, so the one-cycle read latency is hidden and throughput is one word per cycle.

## Interface
- ADDR_WIDTH, 6, memory address width; memory depth DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 64, word width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  controller accepts a word this cycle
- in_data  in  DATA_WIDTH  producer word
- out_valid  out  1  out_data holds the FIFO head
- out_ready  in  1  consumer takes the head this cycle
- out_data  out  DATA_WIDTH  FIFO head word
- WE  out  1  memory write enable
- WADDR  out  ADDR_WIDTH  memory write address
- DIN  out  DATA_WIDTH  memory write data
- RE  out  1  memory read enable
- RADDR  out  ADDR_WIDTH  memory read address
- SE  out  1  memory scan enable; tied 0
- DOUT  in  DATA_WIDTH  memory read data
- count  out  ADDR_WIDTH+2  total words held (memory + in flight + buffer), 0..DEPTH+2

## Operation
- State:
  - wptr, rptr: ADDR_WIDTH bits, wrap modulo DEPTH.
  - mem_cnt: 0..DEPTH.
  - rd_inflight: 1 bit.
  - Output buffer: 2 entries, buf_cnt 0..2, head/tail index.
- Push:
  - in_ready = !RST && mem_cnt < DEPTH, using the registered mem_cnt only. A read issued in the same cycle does not free a slot for that cycle.
  - push = in_valid && in_ready.
  - WE = push; WADDR = wptr; DIN = in_data. All combinational.
  - On push: wptr+1.
- Pop: pop = out_valid && out_ready; out_valid = buf_cnt > 0; out_data = buffer head.
- Read issue:
  - RE = !RST && mem_cnt > 0 && (buf_cnt + rd_inflight − pop) < 2; RADDR = rptr.
  - The combinational path out_ready → RE is permitted.
  - On RE: rptr+1 and rd_inflight set for the next cycle.
  - When rd_inflight=1, DOUT is written into the buffer tail at the next edge.
- mem_cnt next = mem_cnt + push − RE. buf_cnt next = buf_cnt + rd_inflight − pop.
- count = mem_cnt + rd_inflight + buf_cnt (combinational from registers).
- Ordering is strict FIFO. A read never targets an address written at the same edge, because mem_cnt is registered.
- Boundaries:
  - Memory full: in_ready=0 until a read is issued.
  - Memory empty: RE=0.
  - Push and RE in the same cycle at any occupancy: both take effect, mem_cnt unchanged.
  - Buffer full with out_ready=0: RE=0 and the FIFO stalls losslessly.
  - Pointer wrap from DEPTH−1 to 0 is seamless.

## Timing
- Reset, at the first edge with RST=1:
  - wptr, rptr, mem_cnt, rd_inflight, buf_cnt all 0.
  - Outputs: out_valid=0, count=0, WE=0, RE=0, SE=0, in_ready=0 while RST is high.
  - out_data is undefined but must not cause X on out_valid.
- Reset mid-operation: all contents are discarded, and the DOUT of a read already in flight is ignored.
- Latency:
  - Push accepted at edge t, FIFO otherwise empty: RE=1 in the cycle after edge t; DOUT valid after edge t+1; out_valid=1 after edge t+2.
  - First-word latency is therefore 2 cycles.
- Throughput: 1 push and 1 pop per cycle sustained, with no bubbles once out_valid=1 and out_ready is held high.
- Memory contract: WE/WADDR/DIN sampled at the edge; RE/RADDR sampled at edge e; DOUT valid in the cycle after edge e and held until the next RE.

## Test plan
- Reset then single word (ADDR_WIDTH=3): push 0xA5 -> out_valid rises exactly 2 edges after acceptance, out_data=0xA5, count goes 1,1,1 then 0 after the pop.
- Fill to full with out_ready=0: push 0..9 -> in_ready drops after 10 accepts (8 memory + 2 buffer), count=10. Further in_valid is ignored and WE stays 0.
- Streaming: in_valid=out_ready=1 for 100 cycles with random data and an 8-deep memory -> output sequence equals input sequence with no gaps after the first word, and pointers wrap more than 10 times.
- Back-pressure toggling: out_ready random at 50% for 1000 words -> no loss, no duplication, count never exceeds 10, and RE is never issued while buf_cnt + rd_inflight = 2 without a pop.
- Simultaneous push and read at mem_cnt=8: in_ready=0 that cycle, then 1 in the next cycle -> the word accepted next appears after all earlier words.
- Reset with a read in flight: assert RST in the cycle after RE=1 -> out_valid=0 and count=0 after the edge, the stale DOUT is never presented, and the next push 0x3C comes out first.
